// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction memory loader.
// rx: a byte moves on a rising edge where rx_valid & rx_ready; the sender holds rx_data stable until then.
interface imem_loader_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory as
// little-endian words from address 0, holding the CPU (busy) until done or error.
module imem_loader #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [AW:0]       word_count,
    output logic [2:0]        state_dbg
);
    localparam int BPW = DW / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);
    localparam logic [16:0] MAX_LEN = 17'(1) << AW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t         state;
    logic [15:0]    len;
    logic [7:0]     csum;
    logic [BIW-1:0] byte_idx;
    logic [DW-1:0]  word_buf;
    logic [DW-1:0]  word_next;
    logic [15:0]    len_full;
    logic           len_bad;
    logic [AW:0]    wc_inc;
    logic           xfer;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign state_dbg = state;
    assign wc_inc    = word_count + 1'b1;

    // Length check runs on the incoming high byte so ERR is entered straight from LEN1.
    assign len_full = {bus.rx_data, len[7:0]};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);

    always_comb begin
        word_next = word_buf;
        word_next[int'(byte_idx) * 8 +: 8] = bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            csum          <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_count    <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        word_count   <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                        busy         <= 1'b1;
                        bus.rx_ready <= 1'b1;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        len[7:0] <= bus.rx_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= bus.rx_data;
                        if (len_bad) begin
                            state        <= ERR;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                            bus.rx_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_buf <= word_next;
                        csum     <= csum ^ bus.rx_data;
                        // The completed word (including this byte) is presented during WRITE.
                        if (byte_idx == LAST_IDX) begin
                            byte_idx      <= '0;
                            state         <= WRITE;
                            bus.rx_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_count[AW-1:0];
                            bus.mem_wdata <= word_next;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_count   <= wc_inc;
                    bus.rx_ready <= 1'b1;
                    state        <= (17'(wc_inc) == 17'(len)) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are built from word lists, writes are captured from the
// memory port and compared with the words the frame carried, in order, from address 0.
module tb_imem_loader;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BPW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tx_words [1024];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];
    logic [AW+2:0] status;

    imem_loader_if #(.AW(AW), .DW(DW)) bus ();

    imem_loader #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
        end
    end

    task automatic clear_q();
        exp_q.delete();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: rx_ready=%b required 1", bus.rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input int n, input logic [15:0] len_f, input logic [7:0] csum_flip,
                              input bit gaps, input int start_at, input int abort_after, input bit tail);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(len_f[7:0], gaps);
        send_byte(len_f[15:8], gaps);
        for (int w = 0; w < n; w++) begin
            if (w == abort_after) begin
                bus.rx_valid = 1'b0;
                return;
            end
            if (w == start_at) begin
                bus.rx_valid = 1'b0;
                pulse_start();
            end
            for (int k = 0; k < BPW; k++) begin
                b  = tx_words[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gaps);
            end
        end
        if (tail) send_byte(cs ^ csum_flip, gaps);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%b required 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hAA;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.mem_we, busy, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b err=%b wc=%0d required all 0",
                     bus.rx_ready, bus.mem_we, busy, done, error, word_count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.mem_we, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ignores_valid: rdy=%b we=%b busy=%b required 0 0 0", bus.rx_ready, bus.mem_we, busy);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_byte_order();
        clear_q();
        tx_words[0] = 32'h12345678;
        pulse_start();
        send_frame(1, 16'd1, 8'h00, 1'b0, -1, -1, 1'b1);
        wait_idle();
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'h12345678 || got_addr[0] !== '0) begin
            errors++;
            $display("FAIL byte_order: got %0d writes first %h required 1 write 12345678@0", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 32'h0);
        end
    endtask

    task automatic test_long_load(input bit gaps, input int start_at);
        clear_q();
        for (int i = 0; i < 173; i++) begin
            tx_words[i] = 32'h0100_0000 + i;
            exp_q.push_back(32'h0100_0000 + i);
        end
        pulse_start();
        send_frame(173, 16'h00AD, 8'h00, gaps, start_at, -1, 1'b1);
        wait_idle();
        checks++;
        if (got_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL long_count(gaps=%0d): got %0d writes required %0d", gaps, got_data.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL long_write[%0d]: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
        status = {busy, done, error, word_count};
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 11'd173}) begin
            errors++;
            $display("FAIL long_status(gaps=%0d): busy=%b done=%b err=%b wc=%0d required 0 1 0 173",
                     gaps, busy, done, error, word_count);
        end
    endtask

    task automatic test_bad_csum();
        clear_q();
        tx_words[0] = 32'h04030201;
        pulse_start();
        send_frame(1, 16'd1, 8'h01, 1'b0, -1, -1, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'h04030201 || got_addr[0] !== '0) begin
            errors++;
            $display("FAIL csum_writes: got %0d writes required 1 write 04030201@0", got_data.size());
        end
        status = {busy, done, error, word_count};
        checks++;
        if (status !== {1'b0, 1'b0, 1'b1, 11'd1}) begin
            errors++;
            $display("FAIL csum_status: busy=%b done=%b err=%b wc=%0d required 0 0 1 1", busy, done, error, word_count);
        end
    endtask

    task automatic test_bad_len(input logic [15:0] len_f);
        clear_q();
        pulse_start();
        send_frame(0, len_f, 8'h00, 1'b0, -1, -1, 1'b0);
        wait_idle();
        checks++;
        if (got_data.size() != 0) begin
            errors++;
            $display("FAIL badlen_writes(%h): got %0d writes required 0", len_f, got_data.size());
        end
        status = {busy, done, error, word_count};
        checks++;
        if (status !== {1'b0, 1'b0, 1'b1, 11'd0} || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL badlen_status(%h): busy=%b done=%b err=%b wc=%0d rdy=%b required 0 0 1 0 0",
                     len_f, busy, done, error, word_count, bus.rx_ready);
        end
    endtask

    task automatic test_full_mem();
        clear_q();
        for (int i = 0; i < 1024; i++) begin
            tx_words[i] = $urandom;
            exp_q.push_back(tx_words[i]);
        end
        pulse_start();
        send_frame(1024, 16'h0400, 8'h00, 1'b0, -1, -1, 1'b1);
        wait_idle();
        checks++;
        if (got_data.size() != 1024 || got_addr[got_addr.size()-1] !== 10'd1023) begin
            errors++;
            $display("FAIL full_count: got %0d writes required 1024 ending at 1023", got_data.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write[%0d]: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
        status = {busy, done, error, word_count};
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 11'd1024}) begin
            errors++;
            $display("FAIL full_status: busy=%b done=%b err=%b wc=%0d required 0 1 0 1024", busy, done, error, word_count);
        end
    endtask

    task automatic test_rst_mid_load();
        clear_q();
        for (int i = 0; i < 100; i++) tx_words[i] = $urandom;
        for (int i = 0; i < 50; i++) exp_q.push_back(tx_words[i]);
        pulse_start();
        send_frame(100, 16'd100, 8'h00, 1'b0, -1, 50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.mem_we, busy, done, error, word_count, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: rdy=%b we=%b busy=%b done=%b err=%b wc=%0d addr=%0d data=%h required all 0",
                     bus.rx_ready, bus.mem_we, busy, done, error, word_count, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (got_data.size() != 50) begin
            errors++;
            $display("FAIL midrst_count: got %0d writes required 50", got_data.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_write[%0d]: got %h@%0d required %h@%0d", i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
        clear_q();
        tx_words[0] = $urandom;
        tx_words[1] = $urandom;
        exp_q.push_back(tx_words[0]);
        exp_q.push_back(tx_words[1]);
        pulse_start();
        send_frame(2, 16'd2, 8'h00, 1'b1, -1, -1, 1'b1);
        wait_idle();
        checks++;
        if (got_data.size() != 2 || got_data[0] !== exp_q[0] || got_addr[0] !== 10'd0
            || got_data[1] !== exp_q[1] || got_addr[1] !== 10'd1) begin
            errors++;
            $display("FAIL after_rst_writes: got %0d writes required %h@0 %h@1", got_data.size(), exp_q[0], exp_q[1]);
        end
        status = {busy, done, error, word_count};
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 11'd2}) begin
            errors++;
            $display("FAIL after_rst_status: busy=%b done=%b err=%b wc=%0d required 0 1 0 2", busy, done, error, word_count);
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        test_reset();
        test_byte_order();
        test_long_load(1'b0, -1);
        test_bad_csum();
        test_bad_len(16'h0401);
        test_bad_len(16'h0000);
        test_full_mem();
        test_long_load(1'b1, 60);
        test_rst_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
